// File: rtl/data_sram_bridge.sv
// Bridges the core's single-cycle data_sram port to a req/addr_ok/data_ok bus.
// Optional bus-wait timeout is enabled by defining DSB_TIMEOUT_EN.
module data_sram_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        is_read;
  logic        done;
  logic        tmo;

  assign is_read = (req_wen == 4'b0000);

`ifdef DSB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          busy;

  assign busy = (state == ADDR) || (state == DATA);
  assign tmo  = busy && !done && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // wait counter: cleared on entry to ADDR, counts while waiting on the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo;
      if (state == IDLE && cpu_en)
        cnt <= '0;
      else if (busy)
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  // access completes on data_ok once the address phase is accepted
  always_comb begin
    done = 1'b0;
    if (state == ADDR)
      done = bus_addr_ok && bus_data_ok;
    else if (state == DATA)
      done = bus_data_ok;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cpu_en) state_nx = ADDR;
      ADDR: begin
        if (done || tmo)
          state_nx = RESP;
        else if (bus_addr_ok)
          state_nx = DATA;
      end
      DATA: if (done || tmo) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register, request latch and read-data return
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_wen   <= 4'b0000;
      req_addr  <= 32'h0;
      req_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu_en) begin
        req_wen   <= cpu_wen;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (done && is_read)
        cpu_rdata <= bus_rdata;
      else if (tmo && is_read)
        cpu_rdata <= 32'hDEAD_BEEF;
    end
  end

  // bus size from the byte-strobe pattern; reads are full words
  always_comb begin
    case (req_wen)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: bus_size = 2'b00;
      4'b0011, 4'b1100: bus_size = 2'b01;
      default:          bus_size = 2'b10;
    endcase
  end

  assign bus_req   = (state == ADDR);
  assign bus_wr    = |req_wen;
  assign bus_wstrb = req_wen;
  assign bus_addr  = req_addr;
  assign bus_wdata = req_wdata;
  assign stallreq  = cpu_en && !rst && (state != RESP);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Randomized bench for data_sram_bridge against a cycle-schedule model
// derived from the handshake timing rules.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_rdata = 32'h0;

  data_sram_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stallreq(stallreq),
    .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] size_of(input logic [3:0] w);
    if (w == 4'b0000 || w == 4'b1111) return 2'b10;
    if (w == 4'b0011 || w == 4'b1100) return 2'b01;
    if ($countones(w) == 1) return 2'b00;
    return 2'b10;
  endfunction

  // one access: addr_ok after d1 extra ADDR cycles, data_ok d2 cycles later
  task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int d1, input int d2);
    int total = 2 + d1 + d2;
    int ac = 1 + d1;
    int dc = ac + d2;
    logic [31:0] rd = 32'h0;
    for (int c = 0; c <= total; c++) begin
      @(posedge clk); #1;
      cpu_en = 1'b1;
      cpu_wen = wen;
      cpu_addr = addr;
      cpu_wdata = wdata;
      bus_addr_ok = (c == ac) ||
                    ((c == 0 || c > ac) && $urandom_range(0, 1) == 1);
      bus_data_ok = (c == dc) ||
                    ((c < ac || c == total) && $urandom_range(0, 1) == 1);
      bus_rdata = $urandom;
      if (c == dc) rd = bus_rdata;
      #1;
      chk("stallreq", 32'(stallreq), 32'(c < total));
      chk("bus_req", 32'(bus_req), 32'(c >= 1 && c <= ac));
      chk("bus_err", 32'(bus_err), 32'h0);
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      if (c >= 1 && c <= ac) begin
        chk("bus_addr", bus_addr, addr);
        chk("bus_wdata", bus_wdata, wdata);
        chk("bus_wr", 32'(bus_wr), 32'(wen != 4'b0000));
        chk("bus_wstrb", 32'(bus_wstrb), 32'(wen));
        chk("bus_size", 32'(bus_size), 32'(size_of(wen)));
      end
      if (c == dc && wen == 4'b0000) exp_rdata = rd;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      cpu_en = 1'b0;
      bus_addr_ok = $urandom_range(0, 1) == 1;
      bus_data_ok = $urandom_range(0, 1) == 1;
      bus_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(stallreq), 32'h0);
      chk("idle_req", 32'(bus_req), 32'h0);
      chk("idle_rdata", cpu_rdata, exp_rdata);
    end
  endtask

  initial begin
    logic [3:0] wens [8];
    wens = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    rst = 1'b1;
    cpu_en = 1'b0;
    cpu_wen = 4'h0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_wr", 32'(bus_wr), 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_size", 32'(bus_size), 32'h2);
    chk("rst_err", 32'(bus_err), 32'h0);
    chk("rst_stall", 32'(stallreq), 32'h0);

    access(4'h0, 32'h1000, 32'h0, 0, 1);
    chk("word_read", cpu_rdata, exp_rdata);
    idle(1);
    access(4'h4, 32'h2002, 32'h00AB_0000, 2, 1);
    access(4'h0, 32'h0000_0020, 32'h0, 0, 0);
    access(4'h0, 32'h0000_0010, 32'h0, 0, 1);
    access(4'h0, 32'h0000_0014, 32'h0, 1, 2);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 1) ? 4'h0 : wens[$urandom_range(0, 7)];
      access(w, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // reset while waiting in DATA, then a stray data_ok
    access(4'h0, 32'h40, 32'h0, 0, 1);
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h50;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(posedge clk); #1;
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    rst = 1'b1;
    #1 chk("stall_in_rst", 32'(stallreq), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_en = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    exp_rdata = 32'h0;
    #1;
    chk("rst_mid_req", 32'(bus_req), 32'h0);
    chk("rst_mid_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    #1;
    chk("stray_dok_rdata", cpu_rdata, 32'h0);
    chk("stray_dok_req", 32'(bus_req), 32'h0);
    access(4'h0, 32'h60, 32'h0, 1, 0);

`ifdef DSB_TIMEOUT_EN
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      cpu_en = (c <= 9);
      cpu_wen = 4'h0;
      cpu_addr = 32'h80;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      #1;
      if (c <= 9) chk("tmo_stall", 32'(stallreq), 32'(c < 9));
      chk("tmo_err", 32'(bus_err), 32'(c == 9));
      if (c >= 9) chk("tmo_rdata", cpu_rdata, 32'hDEAD_BEEF);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
